lbm_step_sequencer: RTL
=======================

# lbm_step_sequencer

Phase and timestep scheduler for the LBM_DE2 lattice-Boltzmann core. It sweeps the GRID_DIM cell addresses once per phase in the order MACRO (density/velocity), COLLIDE, STREAM, and drains the datapath pipeline between phases. It repeats this for MAX_TIME timesteps and then signals completion. It sits between the top-level control and the p/ux/uy/fin memory-and-arithmetic datapath, and is the only source of cell addresses and phase selects.

## Interface

Parameters:
- GRID_DIM, 256: total lattice cells (16x16).
- GRID_X, 16: cells per row; GRID_DIM must be a multiple of GRID_X.
- MAX_TIME, 100: timesteps per run.
- TIME_COUNT_WIDTH, $clog2(MAX_TIME): step counter width.
- ADDRESS_WIDTH, $clog2(GRID_DIM): cell address width.
- PIPE_DEPTH, 4: datapath latency in cycles; drain length after each sweep; must be at least 1.

Ports:
- CLOCK_50, in, 1: sole clock, rising edge.
- RESET, in, 1: synchronous, active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- cell_ready, in, 1: datapath accepts the current address.
- cell_valid, out, 1: cell_addr/phase are valid this cycle.
- cell_addr, out, ADDRESS_WIDTH: lattice cell index, 0..GRID_DIM-1.
- phase, out, 2: 0 = MACRO, 1 = COLLIDE, 2 = STREAM; 3 only in IDLE/DONE.
- phase_first, out, 1: high with the first beat (addr 0) of each sweep.
- step_count, out, TIME_COUNT_WIDTH: current timestep, 0..MAX_TIME-1.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at end of run.
- cell_boundary, out, 1: cell is on the grid edge (see Configuration).

## Operation

States: IDLE, SWEEP, DRAIN, DONE. A registered phase (0..2) qualifies SWEEP and DRAIN.

- **IDLE**
  - Outputs: cell_valid=0, busy=0, phase=3, step_count and cell_addr hold 0.
  - start=1 -> SWEEP, phase=0, cell_addr=0, step_count=0.
- **SWEEP**
  - cell_valid=1 continuously.
  - A beat is accepted when cell_valid and cell_ready are both high. Each accepted beat advances cell_addr by 1.
  - cell_ready=0 holds cell_addr, phase and cell_valid unchanged (stall). cell_valid never drops mid-sweep.
  - Acceptance at cell_addr = GRID_DIM-1 -> DRAIN with drain counter = PIPE_DEPTH. cell_addr returns to 0.
- **DRAIN**
  - cell_valid=0; phase holds the drained phase.
  - The counter decrements each cycle; cell_ready is ignored.
  - When the counter reaches 1:
    - phase < 2 -> SWEEP with phase+1.
    - phase = 2 and step_count < MAX_TIME-1 -> SWEEP with phase=0, step_count+1.
    - phase = 2 and step_count = MAX_TIME-1 -> DONE.
- **DONE**
  - done=1, busy=1, phase=3 for exactly one cycle, then IDLE.
  - step_count holds MAX_TIME-1 during DONE and clears to 0 on entry to IDLE.
- **Other rules**
  - start is ignored outside IDLE.
  - phase_first = cell_valid && cell_addr==0.
  - Counters never wrap. cell_addr compares against GRID_DIM-1 exactly, so GRID_DIM need not be a power of two.

## Timing

- Reset, applied at any cycle including mid-sweep or mid-drain, gives on the next edge:
  - state IDLE, cell_valid=0, cell_addr=0, phase=3, phase_first=0;
  - step_count=0, busy=0, done=0, cell_boundary=0.
- No beat in flight is completed or reported after reset.
- start sampled high at edge N: first beat at cycle N+1.
- With cell_ready held high:
  - one sweep plus drain = GRID_DIM + PIPE_DEPTH cycles;
  - one timestep = 3*(GRID_DIM + PIPE_DEPTH) cycles;
  - done is high in cycle N+1 + MAX_TIME*3*(GRID_DIM+PIPE_DEPTH).
- Each cycle of cell_ready=0 in SWEEP adds exactly one cycle. Stalls in DRAIN add nothing.
- All outputs are registered or decoded from registers only, with no input-to-output combinational path. The exception is that beat acceptance uses cell_ready in the same cycle.

## Configuration

- LBM_SEQ_BOUNDARY_EN defined:
  - cell_boundary = cell_valid && (row==0 || row==GRID_DIM/GRID_X-1 || col==0 || col==GRID_X-1);
  - row = cell_addr/GRID_X, col = cell_addr%GRID_X, computed with registered row/col counters that advance with cell_addr (no divider).
- LBM_SEQ_BOUNDARY_EN undefined:
  - the cell_boundary port still exists and is tied to 0;
  - the row/col counters are not built.

## Test plan

Bench settings: GRID_DIM=16, GRID_X=4, MAX_TIME=2, PIPE_DEPTH=3 unless stated.

- **Full run, cell_ready=1, start at cycle 0:**
  - 96 beats in total;
  - phase sequence 0,1,2,0,1,2;
  - step_count changes 0->1 at beat 49;
  - done pulses exactly once, at cycle 115; busy drops at cycle 116.
- **Stall:** drop cell_ready for 5 cycles at cell_addr=7 of COLLIDE.
  - cell_addr stays 7 and cell_valid stays 1 throughout;
  - done moves to cycle 120.
- **Drain:** at each sweep end, cell_valid=0 for exactly 3 cycles regardless of cell_ready; phase_first rises on the next cycle.
- **Reset mid-run:** pull RESET low at cell_addr=9 of STREAM in step 0.
  - Next cycle shows IDLE values (cell_valid=0, phase=3, step_count=0, busy=0).
  - A new start replays the run from step 0, phase 0.
- **Ignored start:** pulse start during SWEEP and during DRAIN -> no change to cell_addr, phase or step_count.
- **With LBM_SEQ_BOUNDARY_EN:**
  - cell_boundary=1 for addrs 0-4, 7, 8, 11-15;
  - cell_boundary=0 for addrs 5, 6, 9, 10.
- **Without LBM_SEQ_BOUNDARY_EN:** cell_boundary=0 throughout.

Source files
------------

// File: rtl/lbm_step_sequencer.sv
// lbm_step_sequencer: phase/timestep scheduler sweeping lattice cells through MACRO, COLLIDE, STREAM with pipeline drains
//   CLOCK_50      in   clock, rising edge
//   RESET         in   synchronous active-low reset
//   start         in   begin a run (sampled only in IDLE)
//   cell_ready    in   datapath accepts current address
//   cell_valid    out  cell_addr/phase valid
//   cell_addr     out  lattice cell index
//   phase         out  0 MACRO, 1 COLLIDE, 2 STREAM, 3 idle/done
//   phase_first   out  first beat (addr 0) of a sweep
//   step_count    out  current timestep
//   busy          out  any state but IDLE
//   done          out  one-cycle end-of-run pulse
//   cell_boundary out  cell on grid edge; decoded only when LBM_SEQ_BOUNDARY_EN is defined, else 0
module lbm_step_sequencer #(
    parameter int GRID_DIM         = 256,
    parameter int GRID_X           = 16,
    parameter int MAX_TIME         = 100,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
    parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM),
    parameter int PIPE_DEPTH       = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        start,
    input  logic                        cell_ready,
    output logic                        cell_valid,
    output logic [ADDRESS_WIDTH-1:0]    cell_addr,
    output logic [1:0]                  phase,
    output logic                        phase_first,
    output logic [TIME_COUNT_WIDTH-1:0] step_count,
    output logic                        busy,
    output logic                        done,
    output logic                        cell_boundary
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int DRAIN_WIDTH = $clog2(PIPE_DEPTH + 1);
    localparam logic [ADDRESS_WIDTH-1:0]    LAST_ADDR  = ADDRESS_WIDTH'(GRID_DIM - 1);
    localparam logic [TIME_COUNT_WIDTH-1:0] LAST_STEP  = TIME_COUNT_WIDTH'(MAX_TIME - 1);
    localparam logic [DRAIN_WIDTH-1:0]      DRAIN_LOAD = DRAIN_WIDTH'(PIPE_DEPTH);

    if ((GRID_DIM % GRID_X) != 0 || PIPE_DEPTH < 1) begin : g_param_error
        $error("lbm_step_sequencer: GRID_DIM must be a multiple of GRID_X and PIPE_DEPTH >= 1");
    end

    logic [1:0]                  r_state;
    logic [ADDRESS_WIDTH-1:0]    r_addr;
    logic [1:0]                  r_phase;
    logic [TIME_COUNT_WIDTH-1:0] r_step;
    logic [DRAIN_WIDTH-1:0]      r_drain;
    logic                        w_accept;
    logic                        w_last;

    assign w_accept = (r_state == S_SWEEP) && cell_ready;
    assign w_last   = w_accept && (r_addr == LAST_ADDR);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_phase <= '0;
            r_step  <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SWEEP;
                        r_addr  <= '0;
                        r_phase <= '0;
                        r_step  <= '0;
                    end
                end
                S_SWEEP: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_addr  <= '0;
                        r_drain <= DRAIN_LOAD;
                    end else if (w_accept) begin
                        r_addr <= r_addr + ADDRESS_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // the transition fires on the last drain cycle, so the drain lasts exactly PIPE_DEPTH cycles
                    if (r_drain == DRAIN_WIDTH'(1)) begin
                        if (r_phase != 2'd2) begin
                            r_state <= S_SWEEP;
                            r_phase <= r_phase + 2'd1;
                        end else if (r_step != LAST_STEP) begin
                            r_state <= S_SWEEP;
                            r_phase <= '0;
                            r_step  <= r_step + TIME_COUNT_WIDTH'(1);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_drain <= r_drain - DRAIN_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                    r_step  <= '0;
                end
            endcase
        end
    end

    assign cell_valid  = (r_state == S_SWEEP);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign phase       = (r_state == S_SWEEP || r_state == S_DRAIN) ? r_phase : 2'd3;
    assign phase_first = cell_valid && (r_addr == '0);
    assign cell_addr   = r_addr;
    assign step_count  = r_step;

`ifdef LBM_SEQ_BOUNDARY_EN
    localparam int ROWS  = GRID_DIM / GRID_X;
    localparam int COL_W = (GRID_X > 1) ? $clog2(GRID_X) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // row/col shadow cell_addr so the edge test needs no divider
    always_ff @(posedge CLOCK_50) begin
        if (!RESET || w_last) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_W'(GRID_X - 1)) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign cell_boundary = cell_valid && (r_row == '0 || r_row == ROW_W'(ROWS - 1) ||
                                          r_col == '0 || r_col == COL_W'(GRID_X - 1));
`else
    assign cell_boundary = 1'b0;
`endif
endmodule
